key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced key scanner front-end feeding a 4-entry event FIFO.
// Raw key code / valid are synchronised, debounced by a 4-state FSM, and
// accepted presses are queued for a first-word-fall-through consumer.
// Optional build macro KEY_REPEAT_EN: while a key stays held, re-queue its
// code every REPEAT_CYCLES. Without the macro, each press yields one event.
module key_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int REPEAT_CYCLES   = 13500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key,
  input  logic       key_valid,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic [3:0] ev_code,
  output logic       ev_valid,
  output logic [2:0] ev_count,
  output logic       overflow,
  output logic       busy
);

  // Counter holds up to DEBOUNCE_CYCLES-2: the sample that latches the
  // candidate is stable sample #1 (counter 0), so the DEBOUNCE_CYCLES-th
  // stable sample is the one seen while the counter sits at DEBOUNCE_CYCLES-2
  // (it would step the counter to DEBOUNCE_CYCLES-1).
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DEBOUNCE   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // ---------------- input synchronisers ----------------
  logic [4:0] key_s1_q, key_s2_q;
  logic       kv_s1_q, kv_s2_q;

  // Two-flop synchronisers for the asynchronous scanner inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      kv_s1_q  <= 1'b0;
      kv_s2_q  <= 1'b0;
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      kv_s1_q  <= key_valid;
      kv_s2_q  <= kv_s1_q;
    end
  end

  logic       samp_ok;
  logic [3:0] samp_code;
  logic       samp_match;

  assign samp_ok    = kv_s2_q && !key_s2_q[4];
  assign samp_code  = key_s2_q[3:0];

  // ---------------- debounce FSM ----------------
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;

  assign samp_match = samp_ok && (samp_code == cand_q);

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;

  // Auto-repeat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  // Next-state logic: press/release debounce and push request.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = '0;  // cleared everywhere except while held in PRESSED
`endif
    case (state_q)
      IDLE: begin
        if (samp_ok) begin
          cand_d  = samp_code;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!samp_ok) begin
          state_d = IDLE;
        end else if (samp_code != cand_q) begin
          cand_d = samp_code;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          push    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!samp_match) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end else begin
`ifdef KEY_REPEAT_EN
          if (rep_q == REP_LAST) begin
            push  = 1'b1;
            rep_d = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (samp_match) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, candidate and debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- event FIFO ----------------
  logic [3:0][3:0] mem_q, mem_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]      rd_nxt;
  logic [2:0]      count_q, count_d;
  logic [3:0]      ev_code_q, ev_code_d;
  logic            ovf_q, ovf_d;
  logic            do_pop, do_push, drop, full;

  assign full    = (count_q == 3'd4);
  assign do_pop  = rd_en && (count_q != 3'd0);
  // A pop frees a slot in the same cycle, so push into a full FIFO succeeds then.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_nxt  = rd_ptr_q + 2'd1;

  // FIFO next-state: storage, pointers, occupancy, registered head, overflow.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ev_code_d = ev_code_q;
    ovf_d     = ovf_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = cand_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (do_pop) rd_ptr_d = rd_nxt;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Head register tracks the oldest entry; it holds when the FIFO drains.
    // When full, wr_ptr == rd_ptr, so the slot being overwritten is the one
    // being popped and the new head comes from rd_ptr+1 (read pre-write).
    if (do_pop) begin
      if (count_q >= 3'd2)  ev_code_d = mem_q[rd_nxt];
      else if (do_push)     ev_code_d = cand_q;
    end else if ((count_q == 3'd0) && do_push) begin
      ev_code_d = cand_q;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ev_code_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ev_code_q <= ev_code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ev_code  = ev_code_q;
  assign ev_valid = (count_q != 3'd0);
  assign ev_count = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32).
// A run-length reference model predicts pushed events and FIFO occupancy;
// a negedge monitor checks every pop and the status outputs each cycle.
module tb_key_event_ctrl;
  localparam int DB  = 8;
  localparam int REP = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key = 5'd31;
  logic       key_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] ev_code;
  logic       ev_valid;
  logic [2:0] ev_count;
  logic       overflow;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  key_event_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_code(ev_code), .ev_valid(ev_valid),
    .ev_count(ev_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs reach the debouncer two clocks late. A press is accepted on the
  // DB-th consecutive identical valid sample; a release after DB consecutive
  // samples that are not the held key.
  logic [4:0] m_k1, m_k2;
  logic       m_v1, m_v2;
  bit         m_pressed;
  logic [3:0] m_cand;
  int         m_run, m_rep;
  bit         m_ovf;
  logic [3:0] m_fifo[$];
  logic [3:0] exp_q[$];
  bit         m_ok, m_same, m_push, m_drop, m_rep_en;

  initial begin
`ifdef KEY_REPEAT_EN
    m_rep_en = 1'b1;
`else
    m_rep_en = 1'b0;
`endif
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_k1 = '0; m_k2 = '0; m_v1 = 0; m_v2 = 0;
        m_pressed = 0; m_cand = '0; m_run = 0; m_rep = 0; m_ovf = 0;
        m_fifo.delete();
        exp_q.delete();
      end else begin
        m_ok   = m_v2 && (m_k2 <= 5'd15);
        m_same = m_ok && (m_k2[3:0] == m_cand);
        m_push = 0;
        m_drop = 0;
        if (!m_pressed) begin
          if (!m_ok)                  m_run = 0;
          else if (m_run > 0 && m_same) m_run++;
          else begin m_cand = m_k2[3:0]; m_run = 1; end
          if (m_run == DB) begin
            m_pressed = 1; m_push = 1; m_run = 0; m_rep = 0;
          end
        end else begin
          if (m_same) begin
            m_run = 0;
            m_rep++;
            if (m_rep_en && m_rep == REP) begin m_push = 1; m_rep = 0; end
          end else begin
            m_rep = 0;
            m_run++;
            if (m_run == DB) begin m_pressed = 0; m_run = 0; end
          end
        end
        if (rd_en && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (m_push) begin
          if (m_fifo.size() < 4) begin
            m_fifo.push_back(m_cand);
            exp_q.push_back(m_cand);
          end else m_drop = 1;
        end
        if (m_drop)       m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        m_k2 = m_k1; m_v2 = m_v1;
        m_k1 = key;  m_v1 = key_valid;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ev_count", ev_count, m_fifo.size());
        check("ev_valid", ev_valid, int'(m_fifo.size() > 0));
        check("overflow", overflow, m_ovf);
        check("busy", busy, int'(m_pressed || m_run > 0));
        if (ev_valid && rd_en) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pop_code: got %0d expected none (scoreboard empty) at %0t", ev_code, $time);
          end else begin
            check("pop_code", ev_code, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] k, input logic v, input int n);
    key = k; key_valid = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] k);
    drive(k, 1'b1, DB + 4);
    drive(5'd31, 1'b0, DB + 4);
  endtask

  task automatic pop(input int n);
    rd_en = 1'b1;
    drive(5'd31, 1'b0, n);
    rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ev_valid"}, ev_valid, 0);
    check({tag, "_ev_count"}, ev_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ev_code"}, ev_code, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int codes5[5];
    codes5 = '{1, 2, 3, 4, 6};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single press held 40 cycles: head visible within sync+debounce+1.
    key = 5'd5; key_valid = 1'b1; first = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (first < 0 && ev_valid) first = i;
    end
    check("press_latency_ok", int'(first >= 1 && first <= 2 + DB + 1), 1);
    check("head_code_5", ev_code, 5);
    drive(5'd31, 1'b0, 20);
    check("busy_after_release", busy, 0);
    check("one_event", ev_count, 1);
    pop(2);

    // Short pulse: no event.
    drive(5'd7, 1'b1, 5);
    drive(5'd31, 1'b0, 20);
    check("pulse_no_event", ev_count, 0);
    check("pulse_idle", busy, 0);

    // Five presses without reads: fourth fills, fifth is dropped.
    foreach (codes5[i]) press(5'(codes5[i]));
    check("fill_count", ev_count, 4);
    check("fill_overflow", overflow, 1);
    pop(6);
    clr_ovf = 1'b1;
    drive(5'd31, 1'b0, 1);
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO, pop coinciding with the push of code 9.
    for (int c = 1; c <= 4; c++) press(5'(c));
    drive(5'd9, 1'b1, 1 + DB);
    rd_en = 1'b1;
    drive(5'd9, 1'b1, 1);
    rd_en = 1'b0;
    drive(5'd9, 1'b1, 4);
    drive(5'd31, 1'b0, DB + 4);
    check("pushpop_full_count", ev_count, 4);
    check("pushpop_full_ovf", overflow, 0);
    pop(6);

    // Release glitch shorter than the debounce: still one event.
    drive(5'd3, 1'b1, 20);
    drive(5'd31, 1'b0, 3);
    drive(5'd3, 1'b1, 20);
    drive(5'd31, 1'b0, 20);
    check("glitch_one_event", ev_count, 1);
    pop(3);

    // Reset while debouncing discards the pending press.
    drive(5'd4, 1'b1, 6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    drive(5'd31, 1'b0, 2);
    rst_n = 1'b1;
    drive(5'd31, 1'b0, 20);
    check("midreset_no_event", ev_count, 0);

    // Long hold: auto-repeat only when the feature is built in.
    drive(5'd10, 1'b1, DB + 100);
    drive(5'd31, 1'b0, DB + 4);
    check("hold_events", ev_count, m_rep_en ? 4 : 1);
    pop(6);

    // Randomised traffic.
    for (int s = 0; s < 300; s++) begin
      logic [4:0] k;
      logic       v;
      int         len;
      k   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      v   = ($urandom_range(0, 4) != 0);
      len = $urandom_range(1, 24);
      key = k; key_valid = v;
      for (int c = 0; c < len; c++) begin
        rd_en   = ($urandom_range(0, 9) < 2);
        clr_ovf = ($urandom_range(0, 19) == 0);
        @(posedge clk); #1;
      end
    end
    clr_ovf = 1'b0;
    drive(5'd31, 1'b0, DB + 4);
    pop(10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
